// File: rtl/sdr_16_rd_capture_pkg.sv
// Shared encodings for the 16-bit SDR controller: SDRAM commands, burst types,
// CAS latency codes and the read-capture beat-assembler states.
package sdr_16_pkg;

   // {ras_n, cas_n, we_n}
   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PCH = 3'b010;
   localparam logic [2:0] CMD_RFR = 3'b001;
   localparam logic [2:0] CMD_LMR = 3'b000;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_BEAT4  = 2'b01;
   localparam logic [1:0] BTE_BEAT8  = 2'b10;
   localparam logic [1:0] BTE_BEAT16 = 2'b11;

   localparam logic [2:0] CL_2 = 3'b010;
   localparam logic [2:0] CL_3 = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_B0   = 2'd1,
      ST_B1   = 2'd2
   } asm_state_t;

   function automatic logic [2:0] cl_code(input int cl);
      return (cl == 3) ? CL_3 : CL_2;
   endfunction

endpackage

// File: rtl/sdr_16_rd_capture_if.sv
// Read-capture bus: command strobe and DQ in, packed 32-bit words out with valid/ready.
interface sdr_16_rd_capture_if;
   logic        cmd_read;
   logic [15:0] dq_i;
   logic [31:0] dat_o;
   logic        valid_o;
   logic        ready_i;
   logic        ovf_o;
   logic        busy_o;

   modport master (
      output cmd_read, dq_i, ready_i,
      input  dat_o, valid_o, ovf_o, busy_o
   );

   modport slave (
      input  cmd_read, dq_i, ready_i,
      output dat_o, valid_o, ovf_o, busy_o
   );
endinterface

// File: rtl/sdr_16_rd_fifo.sv
// Synchronous FIFO, depth 2**aw, with a registered head word on pop_dat.
// Latency: push to !empty 1 cycle. Backpressure: push when full is dropped unless a pop frees a slot.
// Pop while empty is ignored.
module sdr_16_rd_fifo #(
   parameter int dw = 32,
   parameter int aw = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [dw-1:0] push_dat,
   input  logic          pop,
   output logic [dw-1:0] pop_dat,
   output logic          full,
   output logic          empty
);
   localparam logic [aw:0] PTR_ONE = {{aw{1'b0}}, 1'b1};

   logic [dw-1:0] mem [2**aw];
   logic [aw:0]   wr_ptr;
   logic [aw:0]   rd_ptr;
   logic [aw:0]   rd_nxt;
   logic [dw-1:0] head_nxt;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Head after this edge: a word written into the slot that becomes head bypasses the array.
   always_comb begin
      rd_nxt   = rd_ptr + {{aw{1'b0}}, pop_ok};
      head_nxt = mem[rd_nxt[aw-1:0]];
      if (push_ok && (wr_ptr[aw-1:0] == rd_nxt[aw-1:0])) begin
         head_nxt = push_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pop_dat <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         rd_ptr  <= rd_nxt;
         pop_dat <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[aw-1:0]] <= push_dat;
      end
   end
endmodule

// File: rtl/sdr_16_rd_capture.sv
// SDR read capture: tracks reads through CAS latency, packs two 16-bit beats into a word.
// Latency: cmd_read at T -> valid_o at T+3+cl (+1 with SDR_RD_CAPTURE_INREG_EN, which registers dq_i).
// Backpressure: ready_i pops the FIFO; a word arriving with the FIFO full and no pop is dropped, ovf_o sticks.
module sdr_16_rd_capture
   import sdr_16_pkg::*;
#(
   parameter int cl      = 2,
   parameter int fifo_aw = 2
) (
   input logic                sdram_clk,
   input logic                sdram_rst,
   sdr_16_rd_capture_if.slave bus
);
   logic [15:0] dq_s;

`ifdef SDR_RD_CAPTURE_INREG_EN
   localparam int D = 1;
   logic [15:0] dq_r;

   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         dq_r <= '0;
      end else begin
         dq_r <= bus.dq_i;
      end
   end
   assign dq_s = dq_r;
`else
   localparam int D = 0;
   assign dq_s = bus.dq_i;
`endif

   // One slot for the controller's registered cmd output, then CAS latency, then the input flop.
   localparam int PIPE_LEN = 1 + cl + D;

   logic [PIPE_LEN-1:0] pipe;
   logic                tail;
   asm_state_t          state;
   logic [15:0]         hi;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;

   assign tail = pipe[PIPE_LEN-1];

   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         pipe <= '0;
      end else begin
         pipe <= {pipe[PIPE_LEN-2:0], bus.cmd_read};
      end
   end

   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         state <= ST_IDLE;
         hi    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tail) begin
                  hi    <= dq_s;
                  state <= ST_B0;
               end
            end
            ST_B0: begin
               state <= ST_B1;
            end
            ST_B1: begin
               if (tail) begin
                  hi    <= dq_s;
                  state <= ST_B0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The second beat goes straight into the FIFO on the edge that samples it.
   assign push = (state == ST_B0);
   assign pop  = !empty && bus.ready_i;

   sdr_16_rd_fifo #(
      .dw(32),
      .aw(fifo_aw)
   ) u_fifo (
      .clk      (sdram_clk),
      .rst      (sdram_rst),
      .push     (push),
      .push_dat ({hi, dq_s}),
      .pop      (pop),
      .pop_dat  (bus.dat_o),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         bus.ovf_o <= 1'b0;
      end else if (push && full && !pop) begin
         bus.ovf_o <= 1'b1;
      end
   end

   assign bus.valid_o = !empty;
   assign bus.busy_o  = (|pipe) || (state != ST_IDLE);

   // Reads issued one cycle apart would land a new first beat on top of an unfinished word.
   a_no_overlap: assert property (@(posedge sdram_clk) disable iff (sdram_rst)
      !(tail && (state == ST_B0)));
endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Bench for sdr_16_rd_capture: directed table, multi-cycle corner sequences, randomized traffic vs queue model.
module tb_sdr_16_rd_capture;
   localparam int CL    = 2;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;
`ifdef SDR_RD_CAPTURE_INREG_EN
   localparam int D = 1;
`else
   localparam int D = 0;
`endif
   // A read issued in cycle t has its word pushed on the edge ending cycle t+PUSH_AT.
   localparam int PUSH_AT = 2 + CL + D;

   logic sdram_clk = 1'b0;
   logic sdram_rst = 1'b0;

   sdr_16_rd_capture_if bus ();

   sdr_16_rd_capture #(
      .cl(CL),
      .fifo_aw(AW)
   ) dut (
      .sdram_clk(sdram_clk),
      .sdram_rst(sdram_rst),
      .bus(bus)
   );

   always #5 sdram_clk = ~sdram_clk;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          last_cmd = -100;
   logic [15:0] dq_hist [int];
   int          reads [$];
   logic [31:0] mq [$];
   logic        m_ovf = 1'b0;

   typedef struct {
      logic [15:0] hi;
      logic [15:0] lo;
      logic [31:0] word;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Check outputs of the current cycle against the model, drive inputs, advance one edge.
   task automatic step(input logic cmd, input logic [15:0] dq, input logic rdy);
      logic exp_busy;
      logic pop;
      logic full;
      exp_busy = 1'b0;
      foreach (reads[i]) begin
         if (cyc > reads[i] && cyc <= reads[i] + PUSH_AT + 1) exp_busy = 1'b1;
      end
      chk("valid", bus.valid_o, mq.size() != 0);
      if (mq.size() != 0) chk("dat", bus.dat_o, mq[0]);
      chk("ovf", bus.ovf_o, m_ovf);
      chk("busy", bus.busy_o, exp_busy);

      bus.cmd_read = cmd;
      bus.dq_i     = dq;
      bus.ready_i  = rdy;
      dq_hist[cyc] = dq;
      if (cmd) last_cmd = cyc;

      pop  = (mq.size() != 0) && rdy;
      full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      foreach (reads[i]) begin
         if (reads[i] + PUSH_AT == cyc) begin
            if (!full || pop) mq.push_back({dq_hist[reads[i] + 1 + CL], dq_hist[reads[i] + 2 + CL]});
            else m_ovf = 1'b1;
         end
      end
      if (cmd) reads.push_back(cyc);
      while (reads.size() != 0 && reads[0] + PUSH_AT < cyc) void'(reads.pop_front());

      @(posedge sdram_clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      sdram_rst    = 1'b1;
      bus.cmd_read = 1'b0;
      bus.ready_i  = 1'b0;
      bus.dq_i     = '0;
      #1;
      chk("rst_valid", bus.valid_o, 1'b0);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_ovf", bus.ovf_o, 1'b0);
      chk("rst_dat", bus.dat_o, 32'h0);
      mq.delete();
      reads.delete();
      m_ovf    = 1'b0;
      last_cmd = -100;
      repeat (2) begin
         @(posedge sdram_clk);
         #1;
         cyc++;
      end
      sdram_rst = 1'b0;
   endtask

   task automatic drain(output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.valid_o) n++;
         step(1'b0, 16'($urandom), 1'b1);
      end
   endtask

   initial begin
      int n;
      logic [15:0] d;
      logic c;

      vecs[0] = '{16'hA5A5, 16'h5A5A, 32'hA5A55A5A};
      vecs[1] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
      vecs[2] = '{16'h0000, 16'hFFFF, 32'h0000FFFF};
      vecs[3] = '{16'h1234, 16'hABCD, 32'h1234ABCD};

      bus.cmd_read = 1'b0;
      bus.ready_i  = 1'b0;
      bus.dq_i     = '0;
      #2 sdram_rst = 1'b1;
      @(posedge sdram_clk);
      #1;
      apply_reset();

      // Single reads: exact first-valid cycle and packing order
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k <= PUSH_AT + 2; k++) begin
            if (k == PUSH_AT) chk("vec_early", bus.valid_o, 1'b0);
            if (k == PUSH_AT + 1) begin
               chk("vec_valid", bus.valid_o, 1'b1);
               chk("vec_dat", bus.dat_o, vecs[v].word);
            end
            d = (k == 1 + CL) ? vecs[v].hi : (k == 2 + CL) ? vecs[v].lo : 16'($urandom);
            step(k == 0, d, 1'b1);
         end
         step(1'b0, 16'($urandom), 1'b1);
      end

      // Four reads two cycles apart: busy never drops, words arrive in order
      for (int k = 0; k <= 6 + PUSH_AT + 2; k++) begin
         if (k >= PUSH_AT + 1 && k <= PUSH_AT + 7 && ((k - PUSH_AT - 1) % 2) == 0) begin
            int j;
            j = (k - PUSH_AT - 1) / 2;
            chk("b2b_valid", bus.valid_o, 1'b1);
            chk("b2b_dat", bus.dat_o, {16'h1000 + 16'(2 * j + 1 + CL), 16'h1000 + 16'(2 * j + 2 + CL)});
         end
         if (k >= 1 && k <= 6 + PUSH_AT + 1) chk("b2b_busy", bus.busy_o, 1'b1);
         step(k < 8 && (k % 2) == 0, 16'h1000 + 16'(k), 1'b1);
      end
      chk("b2b_ovf", bus.ovf_o, 1'b0);

      // Five reads into a depth-4 FIFO with no consumer: fifth word dropped
      for (int k = 0; k < 8 + PUSH_AT + 3; k++) step(k < 10 && (k % 2) == 0, 16'($urandom), 1'b0);
      chk("ovf_set", bus.ovf_o, 1'b1);
      chk("ovf_valid", bus.valid_o, 1'b1);
      drain(n);
      chk("ovf_kept", n, 4);
      chk("ovf_sticky", bus.ovf_o, 1'b1);
      apply_reset();

      // Full FIFO with a pop in the push cycle: word accepted, no overflow
      for (int k = 0; k <= 8 + PUSH_AT; k++) step(k < 10 && (k % 2) == 0, 16'($urandom), k == 8 + PUSH_AT);
      chk("fullpop_ovf", bus.ovf_o, 1'b0);
      chk("fullpop_valid", bus.valid_o, 1'b1);
      drain(n);
      chk("fullpop_count", n, 4);

      // Reset while the second read sits in B0 with a word already buffered
      for (int k = 0; k < 2 + PUSH_AT; k++) step(k == 0 || k == 2, 16'($urandom), 1'b0);
      chk("mid_busy", bus.busy_o, 1'b1);
      chk("mid_valid", bus.valid_o, 1'b1);
      apply_reset();
      for (int k = 0; k < 12; k++) begin
         chk("post_rst_valid", bus.valid_o, 1'b0);
         step(1'b0, 16'($urandom), 1'b1);
      end

      // Randomized traffic respecting the two-cycle command spacing
      for (int k = 0; k < 800; k++) begin
         c = ((cyc - last_cmd) >= 2) && ($urandom_range(0, 2) == 0);
         step(c, 16'($urandom), $urandom_range(0, 9) < 6);
      end
      for (int k = 0; k < 20; k++) step(1'b0, 16'($urandom), 1'b1);
      chk("final_empty", bus.valid_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
